// File: rtl/fp_pkg.sv
// Shared types and constant builders for the iterative floating-point divider.
package fp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ITER,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    C_ZERO,
    C_NORM,
    C_INF,
    C_NAN
  } op_class_t;

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Quotient bits produced: integer bit, MAN_W fraction bits, guard, round.
  function automatic int iter_count(input int man_w);
    return man_w + 3;
  endfunction

  // Infinity magnitude: exponent all ones, fraction zero (sign bit excluded).
  function automatic logic [63:0] inf_bits(input int exp_w, input int man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
  function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
    return inf_bits(exp_w, man_w) | (64'd1 << (man_w - 1));
  endfunction

  // Largest finite magnitude: exponent all ones minus one, fraction all ones.
  function automatic logic [63:0] max_finite_bits(input int exp_w, input int man_w);
    return (inf_bits(exp_w, man_w) - (64'd1 << man_w)) | ((64'd1 << man_w) - 64'd1);
  endfunction

endpackage

// File: rtl/nr_mant_div.sv
// Non-restoring mantissa divider, one quotient bit per step.
// The remainder always stays in [-D, D); after the last step it equals 2R - D,
// where R is the true restoring remainder, so R != 0 exactly when rem != -D.
module nr_mant_div #(
  parameter int MAN_W = 23,
  parameter int N     = MAN_W + 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [MAN_W:0]   dividend,
  input  logic [MAN_W:0]   divisor,
  output logic [N-1:0]     quotient,
  output logic             sticky
);

  localparam int RW = MAN_W + 4;

  logic signed [RW-1:0] rem;
  logic signed [RW-1:0] d_ext;
  logic [MAN_W:0]       div_q;

  assign d_ext  = $signed({3'b000, div_q});
  assign sticky = (rem != -d_ext);

  // Load performs the first trial subtraction; each step records the sign of
  // the current remainder as a quotient bit and adds or subtracts the divisor.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      div_q    <= '0;
      quotient <= '0;
    end else if (load) begin
      rem      <= $signed({3'b000, dividend}) - $signed({3'b000, divisor});
      div_q    <= divisor;
      quotient <= '0;
    end else if (step) begin
      quotient <= {quotient[N-2:0], ~rem[RW-1]};
      rem      <= rem[RW-1] ? (rem <<< 1) + d_ext : (rem <<< 1) - d_ext;
    end
  end

endmodule

// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 divider A/B with valid/ready handshake and DAZ/FTZ.
// Optional macro FP_DIV_RNE_EN: round-to-nearest-even; undefined: truncate.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds valid and data stable until that edge.
module fp_div_iter
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         underflow,
  output logic         div_zero,
  output logic         invalid,
  output state_t       dbg_state
);

  localparam int N  = iter_count(MAN_W);
  localparam int CW = $clog2(N + 1);
  localparam int BIAS = bias_of(EXP_W);
  localparam logic [EXP_W+1:0] BIAS_E   = BIAS[EXP_W+1:0];
  localparam logic [EXP_W:0]   OVF_E    = {1'b0, {EXP_W{1'b1}}};
  localparam logic [CW-1:0]    LAST_CNT = CW'(N - 1);
  localparam logic [63:0] INF64  = inf_bits(EXP_W, MAN_W);
  localparam logic [63:0] QNAN64 = qnan_bits(EXP_W, MAN_W);
  localparam logic [W-2:0] INF_MAG = INF64[W-2:0];
  localparam logic [W-1:0] QNAN    = QNAN64[W-1:0];
`ifndef FP_DIV_RNE_EN
  localparam logic [63:0]  MAXF64   = max_finite_bits(EXP_W, MAN_W);
  localparam logic [W-2:0] MAXF_MAG = MAXF64[W-2:0];
`endif

  state_t state, state_n;
  logic [W-1:0] a_q, b_q;
  logic [CW-1:0] cnt;
  logic [EXP_W+1:0] e_q;   // two's complement biased exponent
  logic sign_q;
  logic [MAN_W-1:0] mant_q;
  logic guard_q, sticky_q;

  logic sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  op_class_t cls_a, cls_b;
  logic spec_hit, spec_dz, spec_inv;
  logic [W-1:0] spec_res;
  logic [N-1:0] quo;
  logic core_sticky;
  logic round_up, round_inc;
  logic [MAN_W:0] mant_r;
  logic [EXP_W+1:0] e_r;
  logic rng_ovf, rng_unf;

  assign {sa, ea, ma} = a_q;
  assign {sb, eb, mb} = b_q;
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign dbg_state = state;

  // Classify both operands; subnormals count as zero.
  always_comb begin
    cls_a = C_NORM;
    cls_b = C_NORM;
    if (ea == '0)      cls_a = C_ZERO;
    else if (ea == '1) cls_a = (ma == '0) ? C_INF : C_NAN;
    if (eb == '0)      cls_b = C_ZERO;
    else if (eb == '1) cls_b = (mb == '0) ? C_INF : C_NAN;
  end

  // Special-operand results, priority NaN > invalid > div-by-zero > inf/zero.
  always_comb begin
    spec_hit = 1'b1;
    spec_dz  = 1'b0;
    spec_inv = 1'b0;
    spec_res = {sa ^ sb, {(W-1){1'b0}}};
    if (cls_a == C_NAN || cls_b == C_NAN) begin
      spec_res = QNAN;
    end else if ((cls_a == C_ZERO && cls_b == C_ZERO) || (cls_a == C_INF && cls_b == C_INF)) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if (cls_a == C_NORM && cls_b == C_ZERO) begin
      spec_res = {sa ^ sb, INF_MAG};
      spec_dz  = 1'b1;
    end else if (cls_a == C_INF) begin
      spec_res = {sa ^ sb, INF_MAG};
    end else if (cls_b == C_INF || cls_a == C_ZERO) begin
      spec_res = {sa ^ sb, {(W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  nr_mant_div #(.MAN_W(MAN_W), .N(N)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (state == S_SETUP && !spec_hit),
    .step     (state == S_ITER),
    .dividend ({1'b1, ma}),
    .divisor  ({1'b1, mb}),
    .quotient (quo),
    .sticky   (core_sticky)
  );

  // Rounding increment, mantissa carry and exponent range checks.
  always_comb begin
    round_up = guard_q & (sticky_q | mant_q[0]);
`ifdef FP_DIV_RNE_EN
    round_inc = round_up;
`else
    // Truncation: the rounding decision is formed but never applied.
    round_inc = round_up & 1'b0;
`endif
    mant_r  = {1'b0, mant_q} + {{MAN_W{1'b0}}, round_inc};
    e_r     = e_q + {{(EXP_W+1){1'b0}}, mant_r[MAN_W]};
    rng_ovf = !e_r[EXP_W+1] && (e_r[EXP_W:0] >= OVF_E);
    rng_unf = e_r[EXP_W+1] || (e_r == '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (in_valid) state_n = S_SETUP;
      S_SETUP: state_n = spec_hit ? S_DONE : S_ITER;
      S_ITER:  if (cnt == LAST_CNT) state_n = S_NORM;
      S_NORM:  state_n = S_ROUND;
      S_ROUND: state_n = S_DONE;
      S_DONE:  if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Operand capture, exponent path, normalisation and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0; b_q <= '0; cnt <= '0; e_q <= '0; sign_q <= 1'b0;
      mant_q <= '0; guard_q <= 1'b0; sticky_q <= 1'b0;
      result <= '0; overflow <= 1'b0; underflow <= 1'b0;
      div_zero <= 1'b0; invalid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          a_q <= A;
          b_q <= B;
        end
        S_SETUP: begin
          cnt       <= '0;
          sign_q    <= sa ^ sb;
          e_q       <= {2'b00, ea} - {2'b00, eb} + BIAS_E;
          result    <= spec_res;
          overflow  <= 1'b0;
          underflow <= 1'b0;
          div_zero  <= spec_dz;
          invalid   <= spec_inv;
        end
        S_ITER: cnt <= cnt + 1'b1;
        S_NORM: begin
          if (quo[N-1]) begin
            mant_q   <= quo[N-2:2];
            guard_q  <= quo[1];
            sticky_q <= quo[0] | core_sticky;
          end else begin
            mant_q   <= quo[N-3:1];
            guard_q  <= quo[0];
            sticky_q <= core_sticky;
            e_q      <= e_q - 1'b1;
          end
        end
        S_ROUND: begin
          overflow  <= rng_ovf;
          underflow <= rng_unf;
          if (rng_ovf) begin
`ifdef FP_DIV_RNE_EN
            result <= {sign_q, INF_MAG};
`else
            result <= {sign_q, MAXF_MAG};
`endif
          end else if (rng_unf) begin
            result <= {sign_q, {(W-1){1'b0}}};
          end else begin
            result <= {sign_q, e_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
